// File: rtl/wlink_traffic_checker.sv
// Wlink receive-side traffic checker: compares accepted beats against a 32-bit Galois LFSR.
// Optional idle timeout in SYNC/CHECK enabled by defining WLINK_CHK_TIMEOUT_EN.
module wlink_traffic_checker #(
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] beat_target,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [7:0]             err_count,
    output logic                   error,
    output logic                   finished
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ERR_W     = 8;
    localparam logic [DATA_W-1:0] LFSR_TAPS = 32'h0040_0007;
    localparam logic [DATA_W-1:0] SEED_EFF  = (SEED == '0) ? 32'h0000_0001 : SEED;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       lfsr_q, lfsr_d;
    logic [COUNT_WIDTH-1:0]  target_q, target_d;
    logic [COUNT_WIDTH-1:0]  beat_count_q, beat_count_d;
    logic [ERR_W-1:0]        err_count_q, err_count_d;
    logic                    error_q, error_d;
    logic                    finished_q, finished_d;
    logic                    in_ready_q, in_ready_d;
    logic                    accept;
    logic                    mismatch;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], 1'b0} ^ (s[DATA_W-1] ? LFSR_TAPS : '0);
    endfunction

    assign accept   = in_valid & in_ready_q;
    assign mismatch = (in_data != lfsr_q);

`ifdef WLINK_CHK_TIMEOUT_EN
    localparam int unsigned IDLE_W = 16;
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        target_d     = target_q;
        beat_count_d = beat_count_q;
        err_count_d  = err_count_q;
        error_d      = error_q;
`ifdef WLINK_CHK_TIMEOUT_EN
        idle_d       = idle_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    lfsr_d       = SEED_EFF;
                    beat_count_d = '0;
                    err_count_d  = '0;
                    error_d      = 1'b0;
                    target_d     = beat_target;
`ifdef WLINK_CHK_TIMEOUT_EN
                    idle_d       = '0;
`endif
                    state_d      = (beat_target == '0) ? ST_DONE : ST_SYNC;
                end
            end
            ST_SYNC, ST_CHECK: begin
                if (accept) begin
                    beat_count_d = beat_count_q + COUNT_WIDTH'(1);
                    lfsr_d       = lfsr_step(lfsr_q);
                    if (mismatch) begin
                        error_d = 1'b1;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                end
`ifdef WLINK_CHK_TIMEOUT_EN
                idle_d = accept ? '0 : idle_q + IDLE_W'(1);
`endif
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    state_d = (beat_count_d == target_q) ? ST_DONE : ST_CHECK;
                end
`ifdef WLINK_CHK_TIMEOUT_EN
                // Stalled link: flag an error and finish so the harness terminates
                else if (idle_d == IDLE_W'(TIMEOUT_CYCLES)) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_SYNC) || (state_d == ST_CHECK);
        finished_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= SEED_EFF;
            target_q     <= '0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            error_q      <= 1'b0;
            finished_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            target_q     <= target_d;
            beat_count_q <= beat_count_d;
            err_count_q  <= err_count_d;
            error_q      <= error_d;
            finished_q   <= finished_d;
            in_ready_q   <= in_ready_d;
        end
    end

`ifdef WLINK_CHK_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign in_ready   = in_ready_q;
    assign beat_count = beat_count_q;
    assign err_count  = err_count_q;
    assign error      = error_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_wlink_traffic_checker.sv
// Directed bench for wlink_traffic_checker; per-beat expected counters go through a scoreboard queue.
module tb_wlink_traffic_checker;

    localparam int unsigned CW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] beat_target = '0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_ready;
    logic [CW-1:0] beat_count;
    logic [7:0]    err_count;
    logic          error;
    logic          finished;

    wlink_traffic_checker #(
        .SEED(32'h0000_0001),
        .COUNT_WIDTH(CW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .beat_target(beat_target),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .beat_count(beat_count),
        .err_count(err_count),
        .error(error),
        .finished(finished)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] cnt;
        logic [31:0] err;
        logic        error;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_lfsr;
    int          m_cnt, m_err, m_target;
    logic        m_error, m_ready, m_done;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".ready"},    32'(in_ready),   32'(m_ready));
        chk({tag, ".finished"}, 32'(finished),   32'(m_done));
        chk({tag, ".count"},    32'(beat_count), 32'(m_cnt));
        chk({tag, ".errcnt"},   32'(err_count),  32'(m_err));
        chk({tag, ".error"},    32'(error),      32'(m_error));
    endtask

    task automatic start_tail(input int target);
        @(posedge clock); #1;
        m_lfsr = 32'h1; m_cnt = 0; m_err = 0; m_error = 1'b0; m_target = target;
        m_ready = (target != 0);
        m_done  = (target == 0);
        chk("start.ready",  32'(in_ready),   32'(m_ready));
        chk("start.count",  32'(beat_count), 32'd0);
        chk("start.errcnt", 32'(err_count),  32'd0);
        chk("start.error",  32'(error),      32'd0);
        if (target != 0) chk("start.finished", 32'(finished), 32'd0);
    endtask

    task automatic start_pass(input int target);
        @(negedge clock);
        enable = 1'b1;
        beat_target = CW'(target);
        in_valid = 1'b0;
        start_tail(target);
    endtask

    task automatic beat(input logic [31:0] data, input logic valid);
        exp_t e;
        bit   pushed = 0;
        @(negedge clock);
        in_data  = data;
        in_valid = valid;
        #1 chk("beat.ready_pre", 32'(in_ready), 32'(m_ready));
        if (valid && m_ready) begin
            m_cnt++;
            if (data != m_lfsr) begin
                if (m_err != 255) m_err++;
                m_error = 1'b1;
            end
            m_lfsr = lfsr_next(m_lfsr);
            if (m_cnt == m_target) begin
                m_ready = 1'b0;
                m_done  = 1'b1;
            end
            sb.push_back('{cnt: 32'(m_cnt), err: 32'(m_err), error: m_error});
            pushed = 1;
        end
        @(posedge clock); #1;
        if (pushed) begin
            e = sb.pop_front();
            chk("sb.count",  32'(beat_count), e.cnt);
            chk("sb.errcnt", 32'(err_count),  e.err);
            chk("sb.error",  32'(error),      32'(e.error));
        end
        chk("beat.finished", 32'(finished), 32'(m_done));
        chk("beat.ready",    32'(in_ready), 32'(m_ready));
    endtask

    task automatic abort_pass();
        @(negedge clock);
        enable   = 1'b0;
        in_valid = 1'b0;
        @(posedge clock); #1;
        m_ready = 1'b0;
        m_done  = 1'b0;
        chk_outputs("abort");
    endtask

    initial begin
        int guard;
        logic [31:0] w;

        // Reset state
        m_lfsr = 32'h1; m_cnt = 0; m_err = 0; m_error = 0; m_ready = 0; m_done = 0; m_target = 0;
        #12;
        chk_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Clean pass with literal LFSR words
        start_pass(4);
        beat(32'h1, 1'b1);
        beat(32'h2, 1'b1);
        beat(32'h4, 1'b1);
        beat(32'h8, 1'b1);
        chk_outputs("clean.end");
        abort_pass();

        // Single corruption on the third beat
        start_pass(4);
        beat(32'h1, 1'b1);
        beat(32'h2, 1'b1);
        beat(32'h5, 1'b1);
        beat(32'h8, 1'b1);
        chk_outputs("corrupt.end");
        abort_pass();

        // Zero target: DONE without ever raising in_ready
        start_pass(0);
        beat(32'h1, 1'b1);
        chk_outputs("zero.end");
        abort_pass();

        // Gapped stream, then extra beats ignored
        start_pass(40);
        guard = 0;
        while (m_cnt < 40 && guard < 1000) begin
            w = m_lfsr;
            beat(w, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("gap.count", 32'(beat_count), 32'd40);
        for (int i = 0; i < 3; i++) beat(32'h1, 1'b1);
        chk_outputs("gap.end");
        abort_pass();

        // Error count saturation
        start_pass(300);
        for (int i = 0; i < 300; i++) begin
            w = m_lfsr ^ 32'h1;
            beat(w, 1'b1);
        end
        chk_outputs("sat.end");
        abort_pass();

        // Abort mid-pass holds values, restart clears them and reseeds the LFSR
        start_pass(4);
        beat(32'h1, 1'b1);
        beat(32'h3, 1'b1);
        abort_pass();
        start_pass(4);
        beat(32'h1, 1'b1);
        beat(32'h2, 1'b1);
        beat(32'h4, 1'b1);
        beat(32'h8, 1'b1);
        chk_outputs("restart.end");
        abort_pass();

`ifdef WLINK_CHK_TIMEOUT_EN
        // Stalled link times out after 16 idle cycles
        start_pass(4);
        beat(32'h1, 1'b1);
        for (int i = 0; i < 15; i++) beat(32'h0, 1'b0);
        @(negedge clock);
        @(posedge clock); #1;
        m_error = 1'b1; m_ready = 1'b0; m_done = 1'b1;
        chk_outputs("timeout");
        abort_pass();
`endif

        // Asynchronous reset mid-pass while a beat is offered
        start_pass(4);
        beat(32'h1, 1'b1);
        beat(32'h2, 1'b1);
        @(negedge clock);
        in_data  = 32'h4;
        in_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        m_cnt = 0; m_err = 0; m_error = 1'b0; m_ready = 1'b0; m_done = 1'b0;
        chk_outputs("midreset");
        @(negedge clock);
        in_valid    = 1'b0;
        enable      = 1'b1;
        beat_target = CW'(4);
        reset_n     = 1'b1;
        start_tail(4);
        beat(32'h1, 1'b1);
        beat(32'h2, 1'b1);
        beat(32'h4, 1'b1);
        beat(32'h8, 1'b1);
        chk_outputs("postreset.end");
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
